// File: rtl/input_port.sv
// rtl/input_port.sv - debounced switch and push-button input block for the CPU I/O bus
module input_port #(
    parameter int SW_WIDTH        = 8,
    parameter int KEY_COUNT       = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 reset_s2,
    input  logic [SW_WIDTH-1:0]  switch_raw,
    input  logic [KEY_COUNT-1:0] key_raw_n,
    input  logic [KEY_COUNT-1:0] key_ack,
    output logic [SW_WIDTH-1:0]  switch_value,
    output logic                 switch_changed,
    output logic [KEY_COUNT-1:0] key_pressed,
    output logic [KEY_COUNT-1:0] key_pending,
    output logic [KEY_COUNT-1:0] key_held
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // State bits double as outputs: bit 1 is "held", bit 0 is "pressed" so
    // key_held and key_pressed come straight from flops.
    typedef enum logic [1:0] {
        RELEASED = 2'b00,
        PRESSED  = 2'b11,
        HELD     = 2'b10
    } key_state_t;

    logic [SW_WIDTH-1:0]  sw_s1, sw_s2, sw_h0, sw_h1, sw_prev, sw_match, sw_next;
    logic [KEY_COUNT-1:0] key_s1, key_s2;
    logic [KEY_COUNT-1:0] key_level, key_h0, key_h1, key_filt, key_match, key_filt_next;
    logic [CNT_W-1:0]     tick_cnt;
    logic                 tick;
    key_state_t           state      [KEY_COUNT];
    key_state_t           state_next [KEY_COUNT];

    // Key history and filter are kept in "pressed = 1" polarity.
    assign key_level     = ~key_s2;
    assign tick          = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign sw_match      = ~(sw_s2 ^ sw_h0) & ~(sw_s2 ^ sw_h1);
    assign sw_next       = (sw_match & sw_s2) | (~sw_match & switch_value);
    assign key_match     = ~(key_level ^ key_h0) & ~(key_level ^ key_h1);
    assign key_filt_next = (key_match & key_level) | (~key_match & key_filt);

    // Two-flop synchronizers on every raw pin.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            sw_s1  <= switch_raw;
            sw_s2  <= sw_s1;
            key_s1 <= key_raw_n;
            key_s2 <= key_s1;
        end
    end

    // Shared sample-tick counter, wraps at DEBOUNCE_CYCLES-1.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Per-bit 3-sample debounce for switches and keys, advanced on each tick.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            sw_h0        <= '0;
            sw_h1        <= '0;
            switch_value <= '0;
            key_h0       <= '0;
            key_h1       <= '0;
            key_filt     <= '0;
        end else if (tick) begin
            sw_h0        <= sw_s2;
            sw_h1        <= sw_h0;
            switch_value <= sw_next;
            key_h0       <= key_level;
            key_h1       <= key_h0;
            key_filt     <= key_filt_next;
        end
    end

    // One change pulse the cycle after switch_value moves, however many bits moved.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            sw_prev        <= '0;
            switch_changed <= 1'b0;
        end else begin
            sw_prev        <= switch_value;
            switch_changed <= |(switch_value ^ sw_prev);
        end
    end

    // Key FSM state registers.
    always_ff @(posedge clock) begin
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (reset_s2) begin
                state[k] <= RELEASED;
            end else begin
                state[k] <= state_next[k];
            end
        end
    end

    // Key FSM next state; a new press is only accepted from RELEASED.
    always_comb begin
        for (int k = 0; k < KEY_COUNT; k++) begin
            state_next[k]  = state[k];
            key_pressed[k] = state[k][0];
            key_held[k]    = state[k][1];
            case (state[k])
                RELEASED: if (tick && key_filt_next[k])  state_next[k] = PRESSED;
                PRESSED:  state_next[k] = HELD;
                HELD:     if (tick && !key_filt_next[k]) state_next[k] = RELEASED;
                default:  state_next[k] = RELEASED;
            endcase
        end
    end

    // Sticky pending flags; a press in the same cycle as an ack keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            key_pending <= '0;
        end else begin
            key_pending <= key_pressed | (key_pending & ~key_ack);
        end
    end

endmodule

// File: tb/tb_input_port.sv
// tb/tb_input_port.sv - randomized scoreboard bench for input_port
module tb_input_port;

    localparam int SW_W = 8;
    localparam int KC   = 2;
    localparam int D    = 4;

    logic            clock     = 1'b0;
    logic            reset_s2  = 1'b1;
    logic [SW_W-1:0] switch_raw = 8'hFF;
    logic [KC-1:0]   key_raw_n = 2'b00;
    logic [KC-1:0]   key_ack   = 2'b00;
    logic [SW_W-1:0] switch_value;
    logic            switch_changed;
    logic [KC-1:0]   key_pressed, key_pending, key_held;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    input_port #(.SW_WIDTH(SW_W), .KEY_COUNT(KC), .DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset_s2(reset_s2), .switch_raw(switch_raw),
        .key_raw_n(key_raw_n), .key_ack(key_ack), .switch_value(switch_value),
        .switch_changed(switch_changed), .key_pressed(key_pressed),
        .key_pending(key_pending), .key_held(key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: pins seen two edges late, sampled every D-th edge after reset,
    // a bit's filtered level follows only three equal consecutive samples,
    // a press event is a released->pressed step of the filtered key level.
    bit              started = 1'b0;
    int              n_edge  = 0;
    logic [SW_W-1:0] m_sw_d1, m_sw_d2, m_sw_h0, m_sw_h1, m_sw_f;
    logic [KC-1:0]   m_ky_d1, m_ky_d2, m_ky_h0, m_ky_h1, m_ky_f, m_pend, m_press_prev;
    logic [SW_W-1:0] sw_q[$];
    int              key_q[$];

    always @(posedge clock) begin
        logic [SW_W-1:0] s_now, s_new;
        logic [KC-1:0]   k_now, k_new, press_now;
        if (reset_s2) begin
            started = 1'b1;
            n_edge = 0;
            m_sw_d1 = '0; m_sw_d2 = '0; m_sw_h0 = '0; m_sw_h1 = '0; m_sw_f = '0;
            m_ky_d1 = '0; m_ky_d2 = '0; m_ky_h0 = '0; m_ky_h1 = '0; m_ky_f = '0;
            m_pend = '0; m_press_prev = '0;
            sw_q.delete();
            key_q.delete();
        end else begin
            s_now = m_sw_d2;
            k_now = ~m_ky_d2;
            m_sw_d2 = m_sw_d1; m_sw_d1 = switch_raw;
            m_ky_d2 = m_ky_d1; m_ky_d1 = key_raw_n;
            n_edge++;
            press_now = '0;
            if (n_edge % D == 0) begin
                s_new = m_sw_f;
                for (int b = 0; b < SW_W; b++)
                    if (s_now[b] == m_sw_h0[b] && s_now[b] == m_sw_h1[b]) s_new[b] = s_now[b];
                if (s_new != m_sw_f) sw_q.push_back(s_new);
                m_sw_f = s_new;
                m_sw_h1 = m_sw_h0; m_sw_h0 = s_now;
                k_new = m_ky_f;
                for (int k = 0; k < KC; k++) begin
                    if (k_now[k] == m_ky_h0[k] && k_now[k] == m_ky_h1[k]) k_new[k] = k_now[k];
                    if (k_new[k] && !m_ky_f[k]) begin
                        press_now[k] = 1'b1;
                        key_q.push_back(k);
                    end
                end
                m_ky_f = k_new;
                m_ky_h1 = m_ky_h0; m_ky_h0 = k_now;
            end
            for (int k = 0; k < KC; k++) begin
                if (m_press_prev[k]) m_pend[k] = 1'b1;
                else if (key_ack[k]) m_pend[k] = 1'b0;
            end
            m_press_prev = press_now;
        end
    end

    // Monitor: level outputs against the model, pulses against the event queues.
    always @(negedge clock) begin
        if (started) begin
            check("switch_value", 32'(switch_value), 32'(m_sw_f));
            check("key_held", 32'(key_held), 32'(m_ky_f));
            check("key_pending", 32'(key_pending), 32'(m_pend));
            if (switch_changed) begin
                if (sw_q.size() == 0) check("switch_changed_unexpected", 32'(1), 32'(0));
                else check("switch_changed_value", 32'(switch_value), 32'(sw_q.pop_front()));
            end
            for (int k = 0; k < KC; k++) begin
                if (key_pressed[k]) begin
                    if (key_q.size() == 0) check("key_pressed_unexpected", 32'(k), 32'(-1));
                    else check("key_pressed_index", 32'(k), 32'(key_q.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int got, pulses;
        bit seen;

        // Reset with switches on and both keys down.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_outputs_zero",
                  32'({switch_value, switch_changed, key_pressed, key_pending, key_held}), 32'(0));
        end
        reset_s2 = 1'b0;
        got = 0;
        for (int i = 1; i <= 15 && got == 0; i++) begin
            @(negedge clock);
            if (switch_value == 8'hFF && key_held == 2'b11) got = i;
        end
        check("post_reset_levels_within_15", 32'(got != 0), 32'(1));
        cyc(3);
        check("post_reset_pending", 32'(key_pending), 32'(2'b11));
        key_raw_n = 2'b11;
        key_ack = 2'b11;
        cyc(1);
        key_ack = 2'b00;
        check("ack_clears_both", 32'(key_pending), 32'(2'b00));
        switch_raw = 8'h00;
        cyc(20);

        // Switch step 00 -> A5.
        switch_raw = 8'hA5;
        got = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (switch_changed) pulses++;
            if (switch_value == 8'hA5 && got == 0) got = i;
        end
        check("switch_a5_within_15", 32'(got >= 1 && got <= 15), 32'(1));
        check("switch_changed_once", 32'(pulses), 32'(1));

        // Bounce on key 0.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) key_raw_n[0] = ~key_raw_n[0];
            @(negedge clock);
            if (key_pressed != 2'b00) pulses++;
        end
        key_raw_n[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (key_pressed != 2'b00) pulses++;
        end
        check("bounce_no_press", 32'(pulses), 32'(0));
        check("bounce_no_pending", 32'(key_pending), 32'(0));

        // Long press on key 1, then ack.
        key_raw_n[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (key_pressed[1]) pulses++;
        end
        check("hold_single_press", 32'(pulses), 32'(1));
        check("hold_pending_set", 32'(key_pending[1]), 32'(1));
        key_ack[1] = 1'b1;
        @(negedge clock);
        key_ack[1] = 1'b0;
        check("ack_clears_pending1", 32'(key_pending[1]), 32'(0));
        key_raw_n[1] = 1'b1;
        cyc(20);

        // Ack in the same cycle as a press on key 0.
        key_raw_n[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (key_pressed[0]) begin
                seen = 1'b1;
                key_ack[0] = 1'b1;
            end
        end
        check("simul_press_seen", 32'(seen), 32'(1));
        @(negedge clock);
        key_ack[0] = 1'b0;
        check("simul_set_wins", 32'(key_pending[0]), 32'(1));

        // Reset with both keys pending and a switch change in flight.
        key_raw_n = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (key_pending == 2'b11) seen = 1'b1;
        end
        check("both_pending_before_reset", 32'(seen), 32'(1));
        switch_raw = 8'h3C;
        cyc(3);
        reset_s2 = 1'b1;
        key_raw_n = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("midrun_reset_zero",
                  32'({switch_value, switch_changed, key_pressed, key_pending, key_held}), 32'(0));
        end
        reset_s2 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (key_pressed != 2'b00) pulses++;
        end
        check("no_stale_press", 32'(pulses), 32'(0));
        check("no_stale_pending", 32'(key_pending), 32'(0));
        check("switch_after_reset", 32'(switch_value), 32'(8'h3C));

        // Randomized pins and acks against the model.
        for (int it = 0; it < 250; it++) begin
            int hold;
            if ($urandom_range(0, 2) == 0) switch_raw = 8'($urandom);
            key_raw_n = 2'($urandom);
            key_ack = 2'($urandom);
            hold = $urandom_range(1, 14);
            @(negedge clock);
            key_ack = 2'b00;
            cyc(hold - 1);
        end
        key_raw_n = 2'b11;
        cyc(20);
        check("switch_queue_drained", 32'(sw_q.size()), 32'(0));
        check("key_queue_drained", 32'(key_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
